scpad_tile_seq: RTL and testbench

- Per-tile beat sequencer that sits directly upstream of the scratchpad swizzle stage.
- Accepts one tile command: base scratchpad address, tile dimensions, and row/column orientation.
- Walks the tile one beat at a time, driving row_or_col, spad_addr, num_rows, num_cols, row_id and col_id into the swizzle interface under a valid/ready handshake.
- Signals completion so the scratchpad controller can issue the next command.

---
 rtl/scpad_tile_seq_if.sv | 43 ++++
 rtl/scpad_tile_seq.sv | 122 ++++++++++++
 tb/tb_scpad_tile_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scpad_tile_seq_if.sv
// Command + beat bundle between the scratchpad controller, the tile sequencer
// and the swizzle stage.
//   master : controller/swizzle side (drives cmd_*, beat_ready)
//   slave  : sequencer side (drives cmd_ready, beat fields, done, busy)
interface scpad_tile_seq_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DIM_W  = 6
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_row_or_col;
  logic [ADDR_W-1:0] cmd_spad_addr;
  logic [DIM_W-1:0]  cmd_num_rows;
  logic [DIM_W-1:0]  cmd_num_cols;

  // Beat channel toward swizzle
  logic              beat_valid;
  logic              beat_ready;
  logic              row_or_col;
  logic [ADDR_W-1:0] spad_addr;
  logic [DIM_W-1:0]  num_rows;
  logic [DIM_W-1:0]  num_cols;
  logic [DIM_W-1:0]  row_id;
  logic [DIM_W-1:0]  col_id;
  logic              beat_last;

  // Status
  logic              done;
  logic              busy;

  modport master (
    output cmd_valid, cmd_row_or_col, cmd_spad_addr, cmd_num_rows, cmd_num_cols, beat_ready,
    input  cmd_ready, beat_valid, row_or_col, spad_addr, num_rows, num_cols, row_id, col_id,
           beat_last, done, busy
  );

  modport slave (
    input  cmd_valid, cmd_row_or_col, cmd_spad_addr, cmd_num_rows, cmd_num_cols, beat_ready,
    output cmd_ready, beat_valid, row_or_col, spad_addr, num_rows, num_cols, row_id, col_id,
           beat_last, done, busy
  );
endinterface

// File: rtl/scpad_tile_seq.sv
// Per-tile beat sequencer feeding the scratchpad swizzle stage.
// Accepts one tile command (base address, rows, cols, orientation), then walks
// the tile one beat per accepted handshake, advancing the address by STRIDE per
// beat, and pulses done for one cycle when the tile is finished.
// Ports:
//   CLK  - rising-edge clock
//   nRST - synchronous active-low reset
//   bus  - scpad_tile_seq_if.slave: command channel in, beat channel out,
//          done/busy status out
module scpad_tile_seq #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DIM_W  = 6,
  parameter int unsigned STRIDE = 32
) (
  input logic             CLK,
  input logic             nRST,
  scpad_tile_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [ADDR_W-1:0] StrideInc = ADDR_W'(STRIDE);

  state_e            state_q;
  logic              cmd_ready_q;
  logic              beat_valid_q;
  logic              done_q;
  logic              busy_q;
  logic              row_or_col_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DIM_W-1:0]  num_rows_q;
  logic [DIM_W-1:0]  num_cols_q;
  logic [DIM_W-1:0]  idx_q;

  logic [DIM_W-1:0]  cmd_count;
  logic [DIM_W-1:0]  count;
  logic [DIM_W-1:0]  last_idx;
  logic              beat_last;
  logic              fire;

  assign cmd_count = bus.cmd_row_or_col ? bus.cmd_num_cols : bus.cmd_num_rows;
  assign count     = row_or_col_q ? num_cols_q : num_rows_q;
  assign last_idx  = count - DIM_W'(1);
  // Gated by beat_valid so a stale idx left over in IDLE never shows as last.
  assign beat_last = beat_valid_q & (idx_q == last_idx);
  assign fire      = beat_valid_q & bus.beat_ready;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= StIdle;
      cmd_ready_q  <= 1'b1;
      beat_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      row_or_col_q <= 1'b0;
      addr_q       <= '0;
      num_rows_q   <= '0;
      num_cols_q   <= '0;
      idx_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            row_or_col_q <= bus.cmd_row_or_col;
            num_rows_q   <= bus.cmd_num_rows;
            num_cols_q   <= bus.cmd_num_cols;
            addr_q       <= bus.cmd_spad_addr;
            idx_q        <= '0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            if (cmd_count != '0) begin
              state_q      <= StRun;
              beat_valid_q <= 1'b1;
            end else begin
              // Empty tile: skip straight to completion.
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (fire) begin
            if (beat_last) begin
              state_q      <= StDone;
              beat_valid_q <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              idx_q  <= idx_q + DIM_W'(1);
              addr_q <= addr_q + StrideInc;  // wraps modulo 2^ADDR_W
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          cmd_ready_q  <= 1'b1;
          beat_valid_q <= 1'b0;
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.beat_valid = beat_valid_q;
  assign bus.row_or_col = row_or_col_q;
  assign bus.spad_addr  = addr_q;
  assign bus.num_rows   = num_rows_q;
  assign bus.num_cols   = num_cols_q;
  assign bus.row_id     = row_or_col_q ? '0 : idx_q;
  assign bus.col_id     = row_or_col_q ? idx_q : '0;
  assign bus.beat_last  = beat_last;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_scpad_tile_seq.sv
module tb_scpad_tile_seq;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DIM_W  = 6;
  localparam int unsigned STRIDE = 32;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  scpad_tile_seq_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

  scpad_tile_seq #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .STRIDE(STRIDE)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DIM_W-1:0]  row_id;
    logic [DIM_W-1:0]  col_id;
    logic [DIM_W-1:0]  num_rows;
    logic [DIM_W-1:0]  num_cols;
    logic              roc;
    logic              last;
  } beat_t;

  typedef struct {
    int acc_cyc;
    int cnt;
    bit full_tp;
  } tile_t;

  beat_t beat_q[$];
  tile_t tile_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    rdy_full = 1'b1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Downstream ready: always high or randomly stalling.
  initial begin
    bus.beat_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      bus.beat_ready = rdy_full ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor / scoreboard
  bit prev_stall = 1'b0;
  bit after_done = 1'b0;
  always @(negedge CLK) begin
    if (!nRST) begin
      prev_stall = 1'b0;
      after_done = 1'b0;
    end else begin
      check("ready_vs_busy", 32'(bus.cmd_ready), 32'(!bus.busy));
      if (after_done) begin
        check("done_one_cycle", 32'(bus.done), 0);
        check("idle_after_done", 32'(bus.busy), 0);
        after_done = 1'b0;
      end
      if (prev_stall) check("valid_held", 32'(bus.beat_valid), 1);
      prev_stall = 1'b0;
      if (bus.beat_valid) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 32'(bus.beat_valid), 0);
        end else begin
          check("spad_addr", 32'(bus.spad_addr), 32'(beat_q[0].addr));
          check("row_id", 32'(bus.row_id), 32'(beat_q[0].row_id));
          check("col_id", 32'(bus.col_id), 32'(beat_q[0].col_id));
          check("beat_last", 32'(bus.beat_last), 32'(beat_q[0].last));
          check("row_or_col", 32'(bus.row_or_col), 32'(beat_q[0].roc));
          check("num_rows", 32'(bus.num_rows), 32'(beat_q[0].num_rows));
          check("num_cols", 32'(bus.num_cols), 32'(beat_q[0].num_cols));
          if (bus.beat_ready) void'(beat_q.pop_front());
          else prev_stall = 1'b1;
        end
      end else begin
        check("last_without_valid", 32'(bus.beat_last), 0);
      end
      if (bus.done) begin
        if (tile_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 0);
        end else begin
          tile_t t;
          t = tile_q.pop_front();
          check("beats_left_at_done", 32'(beat_q.size()), 0);
          if (t.full_tp || t.cnt == 0) check("done_latency", 32'(cyc - t.acc_cyc), 32'(t.cnt + 1));
        end
        after_done = 1'b1;
      end
    end
  end

  // Drive a command and hold it until accepted; the model is pushed at the
  // cycle whose rising edge accepts it.
  task automatic issue(bit roc, logic [ADDR_W-1:0] base, logic [DIM_W-1:0] rows,
                       logic [DIM_W-1:0] cols);
    int waited = 0;
    int cnt;
    bus.cmd_valid      = 1'b1;
    bus.cmd_row_or_col = roc;
    bus.cmd_spad_addr  = base;
    bus.cmd_num_rows   = rows;
    bus.cmd_num_cols   = cols;
    forever begin
      @(negedge CLK);
      if (bus.cmd_ready) break;
      waited++;
      if (waited > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles, required 1", waited);
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    cnt = roc ? int'(cols) : int'(rows);
    for (int i = 0; i < cnt; i++) begin
      beat_t b;
      b.addr     = base + ADDR_W'(i * STRIDE);
      b.row_id   = roc ? '0 : DIM_W'(i);
      b.col_id   = roc ? DIM_W'(i) : '0;
      b.num_rows = rows;
      b.num_cols = cols;
      b.roc      = roc;
      b.last     = (i == cnt - 1);
      beat_q.push_back(b);
    end
    tile_q.push_back('{acc_cyc: cyc, cnt: cnt, full_tp: rdy_full});
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (tile_q.size() != 0 || beat_q.size() != 0 || bus.busy) begin
      @(posedge CLK);
      #1;
      waited++;
      if (waited > 500) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: %0d tiles and %0d beats outstanding, required 0",
                 tile_q.size(), beat_q.size());
        tile_q.delete();
        beat_q.delete();
        return;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.cmd_valid      = 1'b0;
    bus.cmd_row_or_col = 1'b0;
    bus.cmd_spad_addr  = '0;
    bus.cmd_num_rows   = '0;
    bus.cmd_num_cols   = '0;
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_beat_valid", 32'(bus.beat_valid), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_spad_addr", 32'(bus.spad_addr), 0);
    check("rst_beat_last", 32'(bus.beat_last), 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Row walk at full throughput
    rdy_full = 1'b1;
    issue(1'b0, 20'h00100, 6'd4, 6'd8);
    drain();

    // Column walk with backpressure
    rdy_full = 1'b0;
    issue(1'b1, 20'h03000, 6'd3, 6'd2);
    drain();

    // Zero dimension
    rdy_full = 1'b1;
    issue(1'b0, 20'h00200, 6'd0, 6'd5);
    drain();

    // Address wrap
    issue(1'b0, 20'hFFFE0, 6'd2, 6'd3);
    drain();

    // Reset during the second of five beats
    issue(1'b0, 20'h00400, 6'd5, 6'd1);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    beat_q.delete();
    tile_q.delete();
    nRST = 1'b1;
    @(negedge CLK);
    check("midrst_beat_valid", 32'(bus.beat_valid), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("midrst_done", 32'(bus.done), 0);
    @(posedge CLK);
    #1;
    issue(1'b0, 20'h00800, 6'd5, 6'd1);
    drain();

    // New command held during a running tile must wait for IDLE
    issue(1'b0, 20'h01000, 6'd6, 6'd2);
    issue(1'b1, 20'h02000, 6'd3, 6'd4);
    drain();

    // Randomized batches, back-to-back within a batch
    for (int batch = 0; batch < 8; batch++) begin
      rdy_full = batch[0];
      for (int k = 0; k < 5; k++) begin
        logic [ADDR_W-1:0] base;
        logic [DIM_W-1:0]  rows;
        logic [DIM_W-1:0]  cols;
        base = ADDR_W'($urandom());
        rows = ($urandom_range(0, 15) == 0) ? DIM_W'(63) : DIM_W'($urandom_range(0, 10));
        cols = DIM_W'($urandom_range(0, 10));
        issue(1'($urandom_range(0, 1)), base, rows, cols);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
